pwm_demod: RTL and testbench

- Receive-side counterpart of the pedal's PWM output stage.
- Takes a 1-bit PWM stream built from 32-cycle frames (high for `duty` cycles at the start of each frame, duty 0..31) and recovers the 24-bit sample `duty << 19`.
- Used to loop back and check the PWM output.
- Also used as a crude capture path from an external PWM source into the sample domain.

---
 rtl/pwm_demod.sv | 180 ++++++++++++++++++
 tb/tb_pwm_demod.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// pwm_demod -- recovers a sample from a 32-cycle-frame PWM stream.
//
// Each frame is high for `duty` cycles at its start (duty 0..31).
// The block recovers the sample `duty << (SAMPLE_W-FRAME_BITS)`.
// It is used to loop back the pedal's PWM output stage, and as a crude
// capture path from an external PWM source.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-high
//   pwm_in       asynchronous PWM stream
//   sample_out   recovered sample, held between updates
//   sample_valid one-cycle strobe, sample_out is new on this cycle
//   locked       frame alignment confirmed
//   sync_err     one-cycle strobe, an edge arrived off the frame boundary while locked
//
// Optional build macro: PWM_DEMOD_AVERAGE_EN
//   Averages four consecutive frames into one sample.
//   Without the macro, one sample is produced per frame.

module pwm_demod #(
  parameter int FRAME_BITS  = 5,
  parameter int SAMPLE_W    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                locked,
  output logic                sync_err
);

  localparam int N = 1 << FRAME_BITS;
  localparam logic [FRAME_BITS-1:0] POS_LAST     = FRAME_BITS'(N - 1);
  localparam logic [FRAME_BITS:0]   DUTY_MAX     = (FRAME_BITS + 1)'(N - 1);
  localparam logic [FRAME_BITS:0]   TIMEOUT_LAST = (FRAME_BITS + 1)'(2 * N - 1);

  typedef enum logic {ALIGN, MEASURE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pin_s, pin_d, rise;
  logic [FRAME_BITS:0]    timeout;
  logic [FRAME_BITS-1:0]  pos;
  logic [FRAME_BITS:0]    hi_cnt, hi_final;
  logic [FRAME_BITS-1:0]  duty;
  logic                   frame_aligned, sync_err_pend;
  logic                   frame_end, realign;
  logic                   emit_now;
  logic [SAMPLE_W-1:0]    emit_value;

  // Synchroniser chain plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      pin_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pin_d  <= pin_s;
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];
  assign rise  = pin_s & ~pin_d;

  assign frame_end = (state == MEASURE) && (pos == POS_LAST);
  assign realign   = (state == MEASURE) && rise && (pos != '0);

  // An edge on the last frame cycle belongs to the next frame, so it is not counted here.
  assign hi_final = hi_cnt + (FRAME_BITS + 1)'(pin_s & ~rise);
  assign duty     = (hi_final > DUTY_MAX) ? POS_LAST : hi_final[FRAME_BITS-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ALIGN;
    else     state <= state_next;
  end

  // ALIGN leaves on the first edge, or after two silent frames (constant input).
  always_comb begin
    state_next = state;
    case (state)
      ALIGN:   if (rise || (timeout == TIMEOUT_LAST)) state_next = MEASURE;
      MEASURE: state_next = MEASURE;
      default: state_next = ALIGN;
    endcase
  end

`ifdef PWM_DEMOD_AVERAGE_EN
  logic [FRAME_BITS+1:0] acc, acc_sum;
  logic [1:0]            frame_cnt;

  assign acc_sum    = acc + (FRAME_BITS + 2)'(duty);
  assign emit_now   = frame_end && (frame_cnt == 2'd3);
  assign emit_value = SAMPLE_W'(acc_sum) << (SAMPLE_W - FRAME_BITS - 2);

  // A realign on the frame-end cycle still lets the ending frame in, then starts a fresh group of four.
  always_ff @(posedge clk) begin
    if (rst || (state == ALIGN) || realign) begin
      acc       <= '0;
      frame_cnt <= '0;
    end else if (frame_end) begin
      if (frame_cnt == 2'd3) begin
        acc       <= '0;
        frame_cnt <= '0;
      end else begin
        acc       <= acc_sum;
        frame_cnt <= frame_cnt + 2'd1;
      end
    end
  end
`else
  assign emit_now   = frame_end;
  assign emit_value = SAMPLE_W'(duty) << (SAMPLE_W - FRAME_BITS);
`endif

  // Frame tracking, emission and alignment supervision.
  // The cycle after an edge has pos=1, because the edge cycle itself is pos 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      locked        <= 1'b0;
      sync_err      <= 1'b0;
      sync_err_pend <= 1'b0;
      timeout       <= '0;
      pos           <= '0;
      hi_cnt        <= '0;
      frame_aligned <= 1'b0;
    end else begin
      sample_valid  <= emit_now;
      if (emit_now) sample_out <= emit_value;
      // A slip detected on the frame-end cycle is reported one cycle late, clear of the sample strobe.
      sync_err      <= sync_err_pend;
      sync_err_pend <= 1'b0;

      if (state == ALIGN) begin
        if (rise) begin
          timeout       <= '0;
          pos           <= FRAME_BITS'(1);
          hi_cnt        <= (FRAME_BITS + 1)'(1);
          frame_aligned <= 1'b1;
        end else if (timeout == TIMEOUT_LAST) begin
          timeout       <= '0;
          pos           <= '0;
          hi_cnt        <= '0;
          frame_aligned <= 1'b0;
        end else begin
          timeout <= timeout + 1'b1;
        end
      end else begin
        if (frame_end && frame_aligned) locked <= 1'b1;

        if (realign) begin
          pos           <= FRAME_BITS'(1);
          hi_cnt        <= (FRAME_BITS + 1)'(1);
          frame_aligned <= 1'b1;
          locked        <= 1'b0;
          if (locked) begin
            if (frame_end) sync_err_pend <= 1'b1;
            else           sync_err      <= 1'b1;
          end
        end else begin
          pos <= pos + 1'b1;
          if (frame_end) begin
            hi_cnt        <= '0;
            frame_aligned <= 1'b0;
          end else begin
            hi_cnt <= hi_cnt + (FRAME_BITS + 1)'(pin_s);
            if ((pos == '0) && rise) frame_aligned <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod -- directed bench for pwm_demod.
// It drives hand-built PWM frames and logs every sample strobe from a negedge monitor.
// It compares the logged sample values, lock state, strobe spacing and error strobes
// against hand-computed duty sequences.
// Build with PWM_DEMOD_AVERAGE_EN defined to exercise the four-frame averaging path instead.

module tb_pwm_demod;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [23:0] sample_out;
  logic        sample_valid, locked, sync_err;

  pwm_demod dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .locked       (locked),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log, filled on the falling edge away from the active edge.
  logic [23:0] vals[$];
  int          stamps[$];
  logic        lockq[$];
  int          syncErrCnt = 0;
  int          lockDrops = 0;
  int          overlapCnt = 0;
  logic        lockedPrev = 1'b0;

  always @(negedge clk) begin
    if (sample_valid) begin
      vals.push_back(sample_out);
      stamps.push_back(cyc);
      lockq.push_back(locked);
    end
    if (sync_err) syncErrCnt++;
    if (sync_err && sample_valid) overlapCnt++;
    if (lockedPrev && !locked) lockDrops++;
    lockedPrev = locked;
  end

  int checks = 0;
  int failures = 0;
  int relCyc = 0;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task clearLog();
    vals.delete();
    stamps.delete();
    lockq.delete();
    syncErrCnt = 0;
    lockDrops  = 0;
  endtask

  // Drives frame positions first..last of a frame with the given duty, one per clock.
  task applyStimulus(input int duty, input int first, input int last, input logic doReset);
    for (int i = first; i <= last; i++) begin
      @(posedge clk);
      #1;
      pwm_in = (i < duty);
      rst    = doReset;
    end
  endtask

  task sendFrame(input int duty);
    applyStimulus(duty, 0, 31, 1'b0);
  endtask

  task pulseReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst    = 1'b1;
      pwm_in = 1'b0;
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    relCyc = cyc;
  endtask

  task checkSeq(input string tag, input int n, input int d[8], input int shift, input logic lk);
    checkOutput({tag, " count"}, vals.size(), n);
    for (int i = 0; i < n && i < vals.size(); i++) begin
      checkOutput($sformatf("%s val%0d", tag, i), {8'h0, vals[i]}, d[i] << shift);
      checkOutput($sformatf("%s lock%0d", tag, i), {31'h0, lockq[i]}, {31'h0, lk});
    end
  endtask

  initial begin
    $display("[TB] start");
    pulseReset(3);
    checkOutput("reset sample_out", {8'h0, sample_out}, 32'h0);
    checkOutput("reset locked", {31'h0, locked}, 32'h0);
    checkOutput("reset valid", {31'h0, sample_valid}, 32'h0);
    clearLog();

`ifdef PWM_DEMOD_AVERAGE_EN
    sendFrame(10);
    sendFrame(11);
    sendFrame(12);
    sendFrame(13);
    checkOutput("avg no strobe frames1-3", vals.size(), 0);
    sendFrame(10);
    checkSeq("avg", 1, '{46, 0, 0, 0, 0, 0, 0, 0}, 17, 1'b1);
`else
    // Steady duty 12.
    for (int f = 0; f < 5; f++) sendFrame(12);
    checkSeq("duty12", 4, '{12, 12, 12, 12, 0, 0, 0, 0}, 19, 1'b1);
    for (int i = 1; i < stamps.size(); i++)
      checkOutput($sformatf("duty12 period%0d", i), stamps[i] - stamps[i-1], 32);
    checkOutput("duty12 sync_err", syncErrCnt, 0);

    // Duty sweep, including the saturating all-high frame and a carried-over high start.
    clearLog();
    sendFrame(1);
    sendFrame(31);
    sendFrame(0);
    sendFrame(16);
    sendFrame(32);
    sendFrame(16);
    sendFrame(16);
    checkSeq("sweep", 7, '{12, 1, 31, 0, 16, 31, 16, 0}, 19, 1'b1);
    checkOutput("sweep sync_err", syncErrCnt, 0);
    checkOutput("sweep lock drops", lockDrops, 0);

    // Constant low from reset: timeout, then zero samples every frame.
    pulseReset(2);
    clearLog();
    applyStimulus(0, 0, 169, 1'b0);
    checkSeq("lowrun", 3, '{0, 0, 0, 0, 0, 0, 0, 0}, 19, 1'b0);
    if (stamps.size() > 0) checkOutput("lowrun first strobe", stamps[0] - relCyc, 96);
    if (stamps.size() > 1) checkOutput("lowrun period", stamps[1] - stamps[0], 32);
    clearLog();
    for (int f = 0; f < 3; f++) sendFrame(5);
    checkSeq("duty5", 2, '{5, 5, 0, 0, 0, 0, 0, 0}, 19, 1'b1);
    checkOutput("duty5 sync_err", syncErrCnt, 0);

    // Phase slip of 3 cycles while locked on duty 8.
    for (int f = 0; f < 3; f++) sendFrame(8);
    clearLog();
    applyStimulus(8, 0, 28, 1'b0);
    sendFrame(8);
    sendFrame(8);
    checkSeq("slip", 2, '{8, 8, 0, 0, 0, 0, 0, 0}, 19, 1'b1);
    checkOutput("slip sync_err", syncErrCnt, 1);
    checkOutput("slip lock drops", lockDrops, 1);

    // Reset pulse at pos 17 of a duty-20 frame.
    sendFrame(20);
    sendFrame(20);
    applyStimulus(20, 0, 16, 1'b0);
    clearLog();
    applyStimulus(20, 17, 17, 1'b1);
    applyStimulus(20, 18, 18, 1'b0);
    checkOutput("midreset sample_out", {8'h0, sample_out}, 32'h0);
    checkOutput("midreset locked", {31'h0, locked}, 32'h0);
    checkOutput("midreset valid", {31'h0, sample_valid}, 32'h0);
    applyStimulus(20, 19, 31, 1'b0);
    checkOutput("midreset no strobe", vals.size(), 0);
    for (int f = 0; f < 3; f++) sendFrame(20);
    checkSeq("recover", 2, '{20, 20, 0, 0, 0, 0, 0, 0}, 19, 1'b1);
    checkOutput("recover sync_err", syncErrCnt, 0);
`endif

    checkOutput("sync_err/valid overlap", overlapCnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
